// File: rtl/khu_pad_input_conditioner.sv
// Pad-side input conditioner: stretched, synchronously released core reset plus
// per-channel synchroniser, consecutive-cycle debounce filter and rise/fall pulses.
`timescale 1ns/1ps
module khu_pad_input_conditioner #(
  parameter int              N_CH         = 4,
  parameter int              SYNC_STAGES  = 2,
  parameter int              FILT_CYCLES  = 4,
  parameter int              RSTN_STRETCH = 16,
  parameter logic [N_CH-1:0] RST_VAL      = {N_CH{1'b1}}
) (
  input  logic            i_CLK,
  input  logic            i_RSTN,
  input  logic [N_CH-1:0] i_IN,
  input  logic [N_CH-1:0] i_BYPASS,
  output logic            o_RSTN,
  output logic [N_CH-1:0] o_OUT,
  output logic [N_CH-1:0] o_RISE,
  output logic [N_CH-1:0] o_FALL
);

  localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam int SW = (RSTN_STRETCH > 0) ? $clog2(RSTN_STRETCH + 1) : 1;

  logic [SYNC_STAGES-1:0] rst_sync;
  logic                   rst_synced;

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) rst_sync <= '0;
    else         rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_synced = rst_sync[SYNC_STAGES-1];

  // o_RSTN is registered and launched one edge early so it rises on the exact target edge.
  if (RSTN_STRETCH == 0) begin : g_no_stretch
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) o_RSTN <= 1'b0;
      else         o_RSTN <= rst_sync[SYNC_STAGES-2];
    end
  end else begin : g_stretch
    logic [SW-1:0] stretch_cnt;

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) begin
        stretch_cnt <= '0;
        o_RSTN      <= 1'b0;
      end else begin
        if (rst_synced && (stretch_cnt != SW'(RSTN_STRETCH)))
          stretch_cnt <= stretch_cnt + SW'(1);
        o_RSTN <= rst_synced && (stretch_cnt >= SW'(RSTN_STRETCH - 1));
      end
    end
  end

  logic [N_CH-1:0] ch_sync [SYNC_STAGES];
  logic [N_CH-1:0] s;
  logic [CW-1:0]   cnt     [N_CH];
  logic [CW-1:0]   cnt_nxt [N_CH];
  logic [N_CH-1:0] out_nxt;

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      for (int k = 0; k < SYNC_STAGES; k++) ch_sync[k] <= RST_VAL;
    end else begin
      ch_sync[0] <= i_IN;
      for (int k = 1; k < SYNC_STAGES; k++) ch_sync[k] <= ch_sync[k-1];
    end
  end

  assign s = ch_sync[SYNC_STAGES-1];

  always_comb begin
    out_nxt = o_OUT;
    cnt_nxt = '{default: '0};
    for (int i = 0; i < N_CH; i++) begin
      if (i_BYPASS[i]) begin
        out_nxt[i] = s[i];
      end else if (s[i] != o_OUT[i]) begin
        if (cnt[i] == CW'(FILT_CYCLES - 1)) out_nxt[i] = s[i];
        else                                cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      cnt    <= '{default: '0};
      o_OUT  <= RST_VAL;
      o_RISE <= '0;
      o_FALL <= '0;
    end else begin
      cnt    <= cnt_nxt;
      o_OUT  <= out_nxt;
      o_RISE <= out_nxt & ~o_OUT;
      o_FALL <= ~out_nxt & o_OUT;
    end
  end

endmodule

// File: tb/tb_khu_pad_input_conditioner.sv
// Self-checking bench: directed scenarios plus randomized traffic against a history-window model.
// Latency: checks sampled at negedge after each active edge.
// Backpressure: none (stimulus-driven, no flow control).
`timescale 1ns/1ps
module tb_khu_pad_input_conditioner;

    localparam int         N_CH    = 4;
    localparam int         SYNC    = 2;
    localparam int         FILT    = 4;
    localparam int         STRETCH = 16;
    localparam logic [3:0] RST_VAL = 4'hF;
    localparam int         N_RAND  = 600;

    logic       clk = 1'b0;
    logic       i_RSTN = 1'b0;
    logic [3:0] i_IN = 4'hF;
    logic [3:0] i_BYPASS = 4'h0;
    logic       o_RSTN;
    logic [3:0] o_OUT, o_RISE, o_FALL;

    int checks = 0;
    int errors = 0;

    logic [3:0] pad_h [0:1023];
    logic [3:0] byp_h [0:1023];
    logic [3:0] out_h [0:1023];

    khu_pad_input_conditioner #(
        .N_CH(N_CH), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT),
        .RSTN_STRETCH(STRETCH), .RST_VAL(RST_VAL)
    ) dut (
        .i_CLK(clk), .i_RSTN(i_RSTN), .i_IN(i_IN), .i_BYPASS(i_BYPASS),
        .o_RSTN(o_RSTN), .o_OUT(o_OUT), .o_RISE(o_RISE), .o_FALL(o_FALL)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] s_at(int j);
        return (j - SYNC + 1 >= 1) ? pad_h[j - SYNC + 1] : RST_VAL;
    endfunction

    task automatic test_reset;
        i_RSTN = 1'b0; i_IN = 4'hF; i_BYPASS = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_RSTN, o_OUT, o_RISE, o_FALL} !== {1'b0, 4'hF, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", {o_RSTN, o_OUT, o_RISE, o_FALL}, {1'b0, 4'hF, 8'h00});
        end
        #2 i_RSTN = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (o_RSTN !== (n >= SYNC + STRETCH)) begin
                errors++;
                $display("FAIL rstn_release edge %0d: got %b required %b", n, o_RSTN, (n >= SYNC + STRETCH));
            end
        end
        #2 i_RSTN = 1'b0;
        #1;
        checks++;
        if (o_RSTN !== 1'b0) begin
            errors++;
            $display("FAIL rstn_glitch_assert: got %b required 0", o_RSTN);
        end
        i_RSTN = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (o_RSTN !== (n >= SYNC + STRETCH)) begin
                errors++;
                $display("FAIL rstn_after_glitch edge %0d: got %b required %b", n, o_RSTN, (n >= SYNC + STRETCH));
            end
        end
    endtask

    task automatic test_filter_fall;
        i_IN[0] = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (o_OUT[0] !== (n < SYNC + FILT)) begin
                errors++;
                $display("FAIL filt_fall_out edge %0d: got %b required %b", n, o_OUT[0], (n < SYNC + FILT));
            end
            checks++;
            if ({o_RISE[0], o_FALL[0]} !== {1'b0, (n == SYNC + FILT)}) begin
                errors++;
                $display("FAIL filt_fall_pulse edge %0d: got %b required %b", n, {o_RISE[0], o_FALL[0]}, {1'b0, (n == SYNC + FILT)});
            end
        end
        i_IN[0] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_short_pulse;
        for (int len = 3; len <= 4; len++) begin
            int lows, rises, falls;
            lows = 0; rises = 0; falls = 0;
            i_IN[1] = 1'b0;
            for (int n = 1; n <= 16; n++) begin
                @(negedge clk);
                lows  += int'(!o_OUT[1]);
                rises += int'(o_RISE[1]);
                falls += int'(o_FALL[1]);
                if (n == len) i_IN[1] = 1'b1;
            end
            checks++;
            if (lows !== (len == FILT ? FILT : 0)) begin
                errors++;
                $display("FAIL pulse%0d_low_cycles: got %0d required %0d", len, lows, (len == FILT ? FILT : 0));
            end
            checks++;
            if (rises !== (len == FILT ? 1 : 0)) begin
                errors++;
                $display("FAIL pulse%0d_rises: got %0d required %0d", len, rises, (len == FILT ? 1 : 0));
            end
            checks++;
            if (falls !== (len == FILT ? 1 : 0)) begin
                errors++;
                $display("FAIL pulse%0d_falls: got %0d required %0d", len, falls, (len == FILT ? 1 : 0));
            end
        end
    endtask

    task automatic test_bypass;
        int highs, rises;
        i_BYPASS[2] = 1'b1;
        repeat (3) @(negedge clk);
        i_IN[2] = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if ({o_OUT[2], o_FALL[2]} !== {(n < SYNC + 1), (n == SYNC + 1)}) begin
                errors++;
                $display("FAIL bypass_fall edge %0d: got %b required %b", n, {o_OUT[2], o_FALL[2]}, {(n < SYNC + 1), (n == SYNC + 1)});
            end
        end
        highs = 0; rises = 0;
        i_IN[2] = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            highs += int'(o_OUT[2]);
            rises += int'(o_RISE[2]);
            if (n == 1) i_IN[2] = 1'b0;
        end
        checks++;
        if (highs !== 1) begin
            errors++;
            $display("FAIL bypass_glitch_high: got %0d required 1", highs);
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL bypass_glitch_rise: got %0d required 1", rises);
        end
        i_IN[2] = 1'b1;
        repeat (4) @(negedge clk);
        i_BYPASS[2] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_midcount;
        int pulses, bad_out;
        i_IN = 4'h0;
        repeat (4) @(negedge clk);
        checks++;
        if (o_OUT !== 4'hF) begin
            errors++;
            $display("FAIL midcount_pending: got %h required F", o_OUT);
        end
        #2 i_RSTN = 1'b0;
        #1;
        checks++;
        if ({o_RSTN, o_OUT, o_RISE, o_FALL} !== {1'b0, 4'hF, 8'h00}) begin
            errors++;
            $display("FAIL midcount_async_reset: got %h required %h", {o_RSTN, o_OUT, o_RISE, o_FALL}, {1'b0, 4'hF, 8'h00});
        end
        i_IN = 4'hF;
        repeat (3) @(negedge clk);
        #2 i_RSTN = 1'b1;
        pulses = 0; bad_out = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            pulses  += int'(|(o_RISE | o_FALL));
            bad_out += int'(o_OUT !== 4'hF);
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midcount_no_pulses: got %0d required 0", pulses);
        end
        checks++;
        if (bad_out !== 0) begin
            errors++;
            $display("FAIL midcount_out_steady: got %0d required 0", bad_out);
        end
    endtask

    task automatic test_simultaneous;
        for (int dir = 0; dir < 2; dir++) begin
            logic [3:0] from_v, to_v;
            from_v = (dir == 0) ? 4'hF : 4'h0;
            to_v   = ~from_v;
            i_IN = to_v;
            for (int n = 1; n <= 8; n++) begin
                @(posedge clk); @(negedge clk);
                checks++;
                if (o_OUT !== ((n < SYNC + FILT) ? from_v : to_v)) begin
                    errors++;
                    $display("FAIL simul_out dir %0d edge %0d: got %h required %h", dir, n, o_OUT, ((n < SYNC + FILT) ? from_v : to_v));
                end
                checks++;
                if ({o_RISE, o_FALL} !== ((n == SYNC + FILT) ? {to_v, from_v} : 8'h00)) begin
                    errors++;
                    $display("FAIL simul_pulses dir %0d edge %0d: got %h required %h", dir, n, {o_RISE, o_FALL}, ((n == SYNC + FILT) ? {to_v, from_v} : 8'h00));
                end
            end
        end
    endtask

    task automatic test_random;
        logic [3:0] prev, nxt;
        int idx;
        bit ok;
        @(negedge clk);
        i_RSTN = 1'b0; i_IN = 4'hF; i_BYPASS = 4'h0;
        #2 i_RSTN = 1'b1;
        out_h[0] = RST_VAL;
        for (int e = 1; e <= N_RAND; e++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(0, 2) == 0) i_IN[c] = ~i_IN[c];
            if ($urandom_range(0, 39) == 0) begin
                idx = $urandom_range(0, N_CH - 1);
                i_BYPASS[idx] = ~i_BYPASS[idx];
            end
            pad_h[e] = i_IN;
            byp_h[e] = i_BYPASS;
            @(posedge clk); @(negedge clk);
            prev = out_h[e-1];
            for (int c = 0; c < N_CH; c++) begin
                if (byp_h[e][c]) begin
                    nxt[c] = s_at(e - 1)[c];
                end else begin
                    ok = (e >= FILT);
                    for (int j = e - FILT + 1; j <= e; j++)
                        if (j >= 1 && (byp_h[j][c] || s_at(j - 1)[c] == prev[c])) ok = 1'b0;
                    nxt[c] = ok ? ~prev[c] : prev[c];
                end
            end
            out_h[e] = nxt;
            checks++;
            if (o_OUT !== nxt) begin
                errors++;
                $display("FAIL rand_out edge %0d: got %h required %h", e, o_OUT, nxt);
            end
            checks++;
            if (o_RISE !== (nxt & ~prev)) begin
                errors++;
                $display("FAIL rand_rise edge %0d: got %h required %h", e, o_RISE, nxt & ~prev);
            end
            checks++;
            if (o_FALL !== (~nxt & prev)) begin
                errors++;
                $display("FAIL rand_fall edge %0d: got %h required %h", e, o_FALL, ~nxt & prev);
            end
        end
    endtask

    initial begin
        test_reset;
        test_filter_fall;
        test_short_pulse;
        test_bypass;
        test_reset_midcount;
        test_simultaneous;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
